// File: rtl/graphics_command_engine.sv
// Graphics command front end: decodes host op-codes and operands, holds drawing
// state, runs clear/fill pixel engines and arbitrates the display-buffer write port.
module graphics_command_engine #(
  parameter int unsigned DISPLAY_WIDTH  = 640,
  parameter int unsigned DISPLAY_HEIGHT = 400,
  parameter int unsigned PIXEL_BITS     = 4,
  parameter int unsigned COLOR_BITS     = 10,
  localparam int unsigned ADDR_BITS = $clog2(DISPLAY_WIDTH * DISPLAY_HEIGHT),
  localparam int unsigned XY_BITS   = $clog2((DISPLAY_WIDTH > DISPLAY_HEIGHT) ? DISPLAY_WIDTH : DISPLAY_HEIGHT)
) (
  input  logic                  clock_in,
  input  logic                  reset_n_in,
  input  logic [7:0]            op_code_in,
  input  logic                  op_code_valid_in,
  input  logic [7:0]            operand_in,
  input  logic                  operand_valid_in,
  input  logic [31:0]           operand_count_in,
  output logic [XY_BITS-1:0]    cursor_x_out,
  output logic [XY_BITS-1:0]    cursor_y_out,
  output logic [XY_BITS-1:0]    sprite_width_out,
  output logic [1:0]            sprite_color_mode_out,
  output logic [PIXEL_BITS-1:0] sprite_pallet_offset_out,
  output logic                  sprite_enable_out,
  output logic                  sprite_data_valid_out,
  output logic [7:0]            sprite_data_out,
  input  logic                  sprite_write_enable_in,
  input  logic [ADDR_BITS-1:0]  sprite_write_address_in,
  input  logic [PIXEL_BITS-1:0] sprite_write_data_in,
  output logic                  sprite_ready_out,
  input  logic                  sprite_cursor_valid_in,
  input  logic [XY_BITS-1:0]    sprite_cursor_x_in,
  input  logic [XY_BITS-1:0]    sprite_cursor_y_in,
  output logic                  pallet_write_enable_out,
  output logic [PIXEL_BITS-1:0] pallet_write_index_out,
  output logic [COLOR_BITS-1:0] pallet_write_value_out,
  output logic                  pixel_write_enable_out,
  output logic [ADDR_BITS-1:0]  pixel_write_address_out,
  output logic [PIXEL_BITS-1:0] pixel_write_data_out,
  output logic                  show_buffer_out,
  output logic                  busy_out
);

  localparam int unsigned Y_BITS = COLOR_BITS - 6;
  localparam logic [7:0] OP_CLEAR  = 8'h10;
  localparam logic [7:0] OP_PALLET = 8'h11;
  localparam logic [7:0] OP_CURSOR = 8'h12;
  localparam logic [7:0] OP_WIDTH  = 8'h13;
  localparam logic [7:0] OP_MODE   = 8'h14;
  localparam logic [7:0] OP_OFFSET = 8'h15;
  localparam logic [7:0] OP_SPRITE = 8'h16;
  localparam logic [7:0] OP_FILL   = 8'h17;
  localparam logic [7:0] OP_SHOW   = 8'h19;
  localparam logic [XY_BITS:0]   W_EXT   = (XY_BITS+1)'(DISPLAY_WIDTH);
  localparam logic [XY_BITS:0]   H_EXT   = (XY_BITS+1)'(DISPLAY_HEIGHT);
  localparam logic [XY_BITS:0]   ONE_EXT = (XY_BITS+1)'(1);
  localparam logic [XY_BITS-1:0] X_MAX   = XY_BITS'(DISPLAY_WIDTH - 1);
  localparam logic [XY_BITS-1:0] Y_MAX   = XY_BITS'(DISPLAY_HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_FILL} state_e;

  state_e                state_q, state_d;
  logic                  op_valid_q, op_valid_d;
  logic [7:0]            cmd_op_q, cmd_op_d;
  logic [7:0]            byte1_q, byte1_d;
  logic [XY_BITS-1:0]    x_hold_q, x_hold_d;
  logic [XY_BITS-1:0]    fw_q, fw_d, fh_q, fh_d;
  logic [Y_BITS-1:0]     pal_y_q, pal_y_d;
  logic [2:0]            pal_cb_q, pal_cb_d;
  logic [XY_BITS-1:0]    cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [XY_BITS-1:0]    spr_w_q, spr_w_d;
  logic [1:0]            spr_mode_q, spr_mode_d;
  logic [PIXEL_BITS-1:0] spr_off_q, spr_off_d;
  logic                  spr_en_q, spr_en_d, spr_dv_q, spr_dv_d;
  logic [7:0]            spr_data_q, spr_data_d;
  logic                  pal_we_q, pal_we_d;
  logic [PIXEL_BITS-1:0] pal_idx_q, pal_idx_d;
  logic [COLOR_BITS-1:0] pal_val_q, pal_val_d;
  logic                  pix_we_q, pix_we_d;
  logic [ADDR_BITS-1:0]  pix_addr_q, pix_addr_d;
  logic [PIXEL_BITS-1:0] pix_data_q, pix_data_d;
  logic                  show_q, show_d, show_pend_q, show_pend_d;
  logic [PIXEL_BITS-1:0] fill_color_q, fill_color_d, eng_color_q, eng_color_d;
  logic [XY_BITS-1:0]    x_q, x_d, y_q, y_d, x0_q, x0_d;
  logic [XY_BITS:0]      xend_q, xend_d, yend_q, yend_d;
  logic [ADDR_BITS-1:0]  row_base_q, row_base_d;

  logic                  cmd_start, cmd_end, op_beat, clear_go, fill_go;
  logic [XY_BITS-1:0]    xy_val, x_clamp, y_clamp, w_clamp;
  logic [XY_BITS:0]      xsum, ysum, fill_xend, fill_yend;

  // Operand value conditioning; sums carry one extra bit so clipping never wraps
  always_comb begin
    xy_val    = XY_BITS'({byte1_q, operand_in});
    x_clamp   = (xy_val > X_MAX) ? X_MAX : xy_val;
    y_clamp   = (xy_val > Y_MAX) ? Y_MAX : xy_val;
    if (xy_val == '0)                  w_clamp = XY_BITS'(1);
    else if ({1'b0, xy_val} > W_EXT)   w_clamp = XY_BITS'(DISPLAY_WIDTH);
    else                               w_clamp = xy_val;
    xsum      = {1'b0, cur_x_q} + {1'b0, fw_q};
    ysum      = {1'b0, cur_y_q} + {1'b0, xy_val};
    fill_xend = (xsum > W_EXT) ? W_EXT : xsum;
    fill_yend = (ysum > H_EXT) ? H_EXT : ysum;
  end

  assign cmd_start = op_code_valid_in && !op_valid_q;
  assign cmd_end   = !op_code_valid_in && op_valid_q;
  assign op_beat   = op_code_valid_in && operand_valid_in;
  assign clear_go  = cmd_end && (cmd_op_q == OP_CLEAR);
  assign fill_go   = op_beat && (op_code_in == OP_FILL) && (operand_count_in == 32'd5) &&
                     (fw_q != '0) && (fh_q != '0);

  // Next-state: command decode, engine FSM and write-port arbitration
  always_comb begin
    state_d = state_q;       op_valid_d = op_code_valid_in; cmd_op_d = cmd_op_q;
    byte1_d = byte1_q;       x_hold_d = x_hold_q;   fw_d = fw_q;          fh_d = fh_q;
    pal_y_d = pal_y_q;       pal_cb_d = pal_cb_q;   cur_x_d = cur_x_q;    cur_y_d = cur_y_q;
    spr_w_d = spr_w_q;       spr_mode_d = spr_mode_q; spr_off_d = spr_off_q;
    spr_en_d = op_code_valid_in && (op_code_in == OP_SPRITE);
    spr_dv_d = 1'b0;         spr_data_d = spr_data_q;
    pal_we_d = 1'b0;         pal_idx_d = pal_idx_q; pal_val_d = pal_val_q;
    pix_we_d = 1'b0;         pix_addr_d = pix_addr_q; pix_data_d = pix_data_q;
    show_d = 1'b0;           show_pend_d = show_pend_q;
    fill_color_d = fill_color_q; eng_color_d = eng_color_q;
    x_d = x_q; y_d = y_q; x0_d = x0_q; xend_d = xend_q; yend_d = yend_q; row_base_d = row_base_q;

    if (cmd_start) cmd_op_d = op_code_in;
    if (sprite_cursor_valid_in) begin
      cur_x_d = sprite_cursor_x_in;
      cur_y_d = sprite_cursor_y_in;
    end

    if (op_beat) begin
      byte1_d = operand_in;
      case (op_code_in)
        OP_CLEAR:  if (operand_count_in == 32'd1) fill_color_d = operand_in[PIXEL_BITS-1:0];
        OP_PALLET: begin
          if (operand_count_in == 32'd1) pal_idx_d = operand_in[PIXEL_BITS-1:0];
          if (operand_count_in == 32'd2) pal_y_d   = operand_in[7 -: Y_BITS];
          if (operand_count_in == 32'd3) pal_cb_d  = operand_in[7:5];
          if (operand_count_in == 32'd4) begin
            pal_val_d = {pal_y_q, pal_cb_q, operand_in[7:5]};
            pal_we_d  = 1'b1;
          end
        end
        OP_CURSOR: begin
          if (operand_count_in == 32'd2) x_hold_d = x_clamp;
          if (operand_count_in == 32'd4) begin
            cur_x_d = x_hold_q;
            cur_y_d = y_clamp;
          end
        end
        OP_WIDTH:  if (operand_count_in == 32'd2) spr_w_d    = w_clamp;
        OP_MODE:   if (operand_count_in == 32'd1) spr_mode_d = operand_in[1:0];
        OP_OFFSET: if (operand_count_in == 32'd1) spr_off_d  = operand_in[PIXEL_BITS-1:0];
        OP_SPRITE: begin
          spr_dv_d   = 1'b1;
          spr_data_d = operand_in;
        end
        OP_FILL: begin
          if (operand_count_in == 32'd2) fw_d = xy_val;
          if (operand_count_in == 32'd4) fh_d = xy_val;
        end
        default: ;
      endcase
    end

    // A show request waits until both engines have finished writing
    if (cmd_start && (op_code_in == OP_SHOW)) begin
      if (state_q != S_IDLE) show_pend_d = 1'b1;
      else                   show_d      = 1'b1;
    end
    if (show_pend_q && (state_q == S_IDLE)) begin
      show_d      = 1'b1;
      show_pend_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (sprite_write_enable_in) begin
          pix_we_d   = 1'b1;
          pix_addr_d = sprite_write_address_in;
          pix_data_d = sprite_write_data_in;
        end
        if (clear_go) begin
          state_d = S_CLEAR; eng_color_d = fill_color_q;
          x_d = '0; y_d = '0; x0_d = '0; xend_d = W_EXT; yend_d = H_EXT; row_base_d = '0;
        end else if (fill_go) begin
          state_d = S_FILL; eng_color_d = operand_in[PIXEL_BITS-1:0];
          x_d = cur_x_q; y_d = cur_y_q; x0_d = cur_x_q;
          xend_d = fill_xend; yend_d = fill_yend;
          row_base_d = ADDR_BITS'(32'(cur_y_q) * DISPLAY_WIDTH);
        end
      end
      S_CLEAR, S_FILL: begin
        pix_we_d   = 1'b1;
        pix_addr_d = row_base_q + ADDR_BITS'(x_q);
        pix_data_d = eng_color_q;
        if (({1'b0, x_q} + ONE_EXT) == xend_q) begin
          x_d        = x0_q;
          y_d        = y_q + XY_BITS'(1);
          row_base_d = row_base_q + ADDR_BITS'(DISPLAY_WIDTH);
          if (({1'b0, y_q} + ONE_EXT) == yend_q) state_d = S_IDLE;
        end else begin
          x_d = x_q + XY_BITS'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= S_IDLE;  op_valid_q <= 1'b0;  cmd_op_q <= '0;  byte1_q <= '0;
      x_hold_q <= '0;     fw_q <= '0;          fh_q <= '0;
      pal_y_q <= '0;      pal_cb_q <= '0;      cur_x_q <= '0;   cur_y_q <= '0;
      spr_w_q <= XY_BITS'(25); spr_mode_q <= 2'b11; spr_off_q <= '0;
      spr_en_q <= 1'b0;   spr_dv_q <= 1'b0;    spr_data_q <= '0;
      pal_we_q <= 1'b0;   pal_idx_q <= '0;     pal_val_q <= '0;
      pix_we_q <= 1'b0;   pix_addr_q <= '0;    pix_data_q <= '0;
      show_q <= 1'b0;     show_pend_q <= 1'b0;
      fill_color_q <= '0; eng_color_q <= '0;
      x_q <= '0; y_q <= '0; x0_q <= '0; xend_q <= '0; yend_q <= '0; row_base_q <= '0;
    end else begin
      state_q <= state_d;  op_valid_q <= op_valid_d;  cmd_op_q <= cmd_op_d;  byte1_q <= byte1_d;
      x_hold_q <= x_hold_d; fw_q <= fw_d;            fh_q <= fh_d;
      pal_y_q <= pal_y_d;  pal_cb_q <= pal_cb_d;     cur_x_q <= cur_x_d;    cur_y_q <= cur_y_d;
      spr_w_q <= spr_w_d;  spr_mode_q <= spr_mode_d; spr_off_q <= spr_off_d;
      spr_en_q <= spr_en_d; spr_dv_q <= spr_dv_d;    spr_data_q <= spr_data_d;
      pal_we_q <= pal_we_d; pal_idx_q <= pal_idx_d;  pal_val_q <= pal_val_d;
      pix_we_q <= pix_we_d; pix_addr_q <= pix_addr_d; pix_data_q <= pix_data_d;
      show_q <= show_d;    show_pend_q <= show_pend_d;
      fill_color_q <= fill_color_d; eng_color_q <= eng_color_d;
      x_q <= x_d; y_q <= y_d; x0_q <= x0_d; xend_q <= xend_d; yend_q <= yend_d;
      row_base_q <= row_base_d;
    end
  end

  assign cursor_x_out             = cur_x_q;
  assign cursor_y_out             = cur_y_q;
  assign sprite_width_out         = spr_w_q;
  assign sprite_color_mode_out    = spr_mode_q;
  assign sprite_pallet_offset_out = spr_off_q;
  assign sprite_enable_out        = spr_en_q;
  assign sprite_data_valid_out    = spr_dv_q;
  assign sprite_data_out          = spr_data_q;
  assign sprite_ready_out         = (state_q == S_IDLE);
  assign pallet_write_enable_out  = pal_we_q;
  assign pallet_write_index_out   = pal_idx_q;
  assign pallet_write_value_out   = pal_val_q;
  assign pixel_write_enable_out   = pix_we_q;
  assign pixel_write_address_out  = pix_addr_q;
  assign pixel_write_data_out     = pix_data_q;
  assign show_buffer_out          = show_q;
  assign busy_out                 = (state_q != S_IDLE);

endmodule

// File: tb/tb_graphics_command_engine.sv
// Directed bench for graphics_command_engine on a reduced 20x12 display.
module tb_graphics_command_engine;

  localparam int unsigned W  = 20;
  localparam int unsigned H  = 12;
  localparam int unsigned XY = 5;
  localparam int unsigned AB = 8;
  localparam int unsigned PB = 4;
  localparam int unsigned CB = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    op_code = '0;
  logic          op_valid = 1'b0;
  logic [7:0]    operand = '0;
  logic          operand_valid = 1'b0;
  logic [31:0]   operand_count = '0;
  logic [XY-1:0] cur_x, cur_y, spr_width;
  logic [1:0]    spr_mode;
  logic [PB-1:0] spr_off;
  logic          spr_en, spr_dv;
  logic [7:0]    spr_data;
  logic          spr_we = 1'b0;
  logic [AB-1:0] spr_addr = '0;
  logic [PB-1:0] spr_wdata = '0;
  logic          spr_ready;
  logic          spr_cur_valid = 1'b0;
  logic [XY-1:0] spr_cur_x = '0, spr_cur_y = '0;
  logic          pal_we;
  logic [PB-1:0] pal_idx;
  logic [CB-1:0] pal_val;
  logic          pix_we;
  logic [AB-1:0] pix_addr;
  logic [PB-1:0] pix_data;
  logic          show, busy;

  int tests_run = 0;
  int tests_failed = 0;

  graphics_command_engine #(.DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H), .PIXEL_BITS(PB), .COLOR_BITS(CB)) dut (
    .clock_in(clk), .reset_n_in(rst_n),
    .op_code_in(op_code), .op_code_valid_in(op_valid),
    .operand_in(operand), .operand_valid_in(operand_valid), .operand_count_in(operand_count),
    .cursor_x_out(cur_x), .cursor_y_out(cur_y),
    .sprite_width_out(spr_width), .sprite_color_mode_out(spr_mode),
    .sprite_pallet_offset_out(spr_off), .sprite_enable_out(spr_en),
    .sprite_data_valid_out(spr_dv), .sprite_data_out(spr_data),
    .sprite_write_enable_in(spr_we), .sprite_write_address_in(spr_addr),
    .sprite_write_data_in(spr_wdata), .sprite_ready_out(spr_ready),
    .sprite_cursor_valid_in(spr_cur_valid), .sprite_cursor_x_in(spr_cur_x),
    .sprite_cursor_y_in(spr_cur_y),
    .pallet_write_enable_out(pal_we), .pallet_write_index_out(pal_idx),
    .pallet_write_value_out(pal_val),
    .pixel_write_enable_out(pix_we), .pixel_write_address_out(pix_addr),
    .pixel_write_data_out(pix_data),
    .show_buffer_out(show), .busy_out(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Operand bytes are taken MSB-first from ops; returns at the negedge after the last operand
  task automatic send_cmd(input logic [7:0] op, input int n, input logic [39:0] ops);
    op_code  = op;
    op_valid = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      operand       = ops[39-8*i -: 8];
      operand_valid = 1'b1;
      operand_count = 32'(i + 1);
      tick();
    end
    operand_valid = 1'b0;
    op_valid      = 1'b0;
  endtask

  initial begin
    int busy_cnt, ready_low, nwr, bad, first_idx, last_idx, show_cnt, show_idx, accept_idx;
    bit spr_req, drop_next;
    int exp_addr[$];
    int wr_addr[$];
    int wr_data[$];
    int wr_idx[$];

    idle(2);
    check_eq("rst_pix_we",   32'(pix_we), 32'd0);
    check_eq("rst_busy",     32'(busy), 32'd0);
    check_eq("rst_ready",    32'(spr_ready), 32'd1);
    check_eq("rst_width",    32'(spr_width), 32'd25);
    check_eq("rst_mode",     32'(spr_mode), 32'd3);
    check_eq("rst_offset",   32'(spr_off), 32'd0);
    check_eq("rst_cursor",   32'({cur_x, cur_y}), 32'd0);
    check_eq("rst_pal_we",   32'(pal_we), 32'd0);
    check_eq("rst_show",     32'(show), 32'd0);
    check_eq("rst_spr_en",   32'(spr_en), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Palette: index 2, value 1010_011_111
    send_cmd(8'h11, 4, {8'h02, 8'hA0, 8'h60, 8'hE0, 8'h00});
    check_eq("pal_we_pulse", 32'(pal_we), 32'd1);
    check_eq("pal_idx",      32'(pal_idx), 32'd2);
    check_eq("pal_val",      32'(pal_val), 32'h29F);
    tick();
    check_eq("pal_we_end",   32'(pal_we), 32'd0);

    // Cursor clamp (31,30) -> (19,11), then in-range move
    send_cmd(8'h12, 4, {8'h00, 8'h1F, 8'h00, 8'h1E, 8'h00});
    check_eq("cur_clamp_x", 32'(cur_x), 32'd19);
    check_eq("cur_clamp_y", 32'(cur_y), 32'd11);
    tick();
    send_cmd(8'h12, 4, {8'h00, 8'h05, 8'h00, 8'h03, 8'h00});
    check_eq("cur_move", 32'({cur_x, cur_y}), 32'({5'd5, 5'd3}));
    tick();

    // Sprite width clamps to 1..W, mode and offset
    send_cmd(8'h13, 2, {8'h00, 8'h00, 24'h0});
    check_eq("width_min", 32'(spr_width), 32'd1);
    tick();
    send_cmd(8'h13, 2, {8'h00, 8'h30, 24'h0});
    check_eq("width_mid", 32'(spr_width), 32'd16);
    tick();
    send_cmd(8'h13, 2, {8'h00, 8'h1F, 24'h0});
    check_eq("width_max", 32'(spr_width), 32'd20);
    tick();
    send_cmd(8'h14, 1, {8'h06, 32'h0});
    check_eq("color_mode", 32'(spr_mode), 32'd2);
    tick();
    send_cmd(8'h15, 1, {8'hA7, 32'h0});
    check_eq("pal_offset", 32'(spr_off), 32'd7);
    tick();

    // Sprite byte stream
    op_code = 8'h16; op_valid = 1'b1;
    tick();
    check_eq("spr_en_on", 32'(spr_en), 32'd1);
    check_eq("spr_dv_idle", 32'(spr_dv), 32'd0);
    operand = 8'h5A; operand_valid = 1'b1; operand_count = 32'd1;
    tick();
    check_eq("spr_dv_pulse", 32'(spr_dv), 32'd1);
    check_eq("spr_data", 32'(spr_data), 32'h5A);
    operand_valid = 1'b0;
    tick();
    check_eq("spr_dv_end", 32'(spr_dv), 32'd0);
    op_valid = 1'b0;
    idle(2);
    check_eq("spr_en_off", 32'(spr_en), 32'd0);

    // Sprite engine cursor update
    spr_cur_valid = 1'b1; spr_cur_x = 5'd7; spr_cur_y = 5'd2;
    tick();
    spr_cur_valid = 1'b0;
    check_eq("spr_cursor", 32'({cur_x, cur_y}), 32'({5'd7, 5'd2}));
    tick();

    // Clipped fill from (15,9), w=10 h=5 colour 5, with a sprite write held off
    send_cmd(8'h12, 4, {8'h00, 8'h0F, 8'h00, 8'h09, 8'h00});
    tick();
    for (int y = 9; y < 12; y++)
      for (int x = 15; x < 20; x++) exp_addr.push_back(y * 20 + x);
    send_cmd(8'h17, 5, {8'h00, 8'h0A, 8'h00, 8'h05, 8'h05});
    spr_we = 1'b1; spr_addr = 8'h33; spr_wdata = 4'hC;
    spr_req = 1'b1; drop_next = 1'b0;
    busy_cnt = 0; ready_low = 0; accept_idx = -1;
    for (int i = 0; i < 30; i++) begin
      if (busy) busy_cnt++;
      if (!spr_ready) ready_low++;
      if (pix_we) begin
        wr_addr.push_back(int'(pix_addr));
        wr_data.push_back(int'(pix_data));
        wr_idx.push_back(i);
      end
      if (drop_next) begin
        spr_we = 1'b0; spr_req = 1'b0; drop_next = 1'b0;
      end else if (spr_req && spr_ready) begin
        accept_idx = i; drop_next = 1'b1;
      end
      tick();
    end
    check_eq("fill_busy_cycles", 32'(busy_cnt), 32'd15);
    check_eq("fill_ready_low",   32'(ready_low), 32'd15);
    check_eq("fill_nwrites",     32'(wr_addr.size()), 32'd16);
    if (wr_addr.size() == 16) begin
      for (int k = 0; k < 15; k++) begin
        check_eq($sformatf("fill_addr%0d", k), 32'(wr_addr[k]), 32'(exp_addr[k]));
        check_eq($sformatf("fill_data%0d", k), 32'(wr_data[k]), 32'd5);
      end
      check_eq("fill_first_idx", 32'(wr_idx[0]), 32'd1);
      check_eq("spr_accept_idx", 32'(accept_idx), 32'd15);
      check_eq("spr_wr_idx",     32'(wr_idx[15]), 32'(accept_idx + 1));
      check_eq("spr_wr_addr",    32'(wr_addr[15]), 32'h33);
      check_eq("spr_wr_data",    32'(wr_data[15]), 32'hC);
    end
    check_eq("fill_cursor", 32'({cur_x, cur_y}), 32'({5'd15, 5'd9}));

    // Clear to colour 3; show and a second clear arrive while busy
    send_cmd(8'h10, 1, {8'h03, 32'h0});
    tick();
    busy_cnt = 0; nwr = 0; bad = 0; first_idx = -1; last_idx = -1; show_cnt = 0; show_idx = -1;
    for (int i = 0; i < 300; i++) begin
      if (busy) busy_cnt++;
      if (pix_we) begin
        if (int'(pix_addr) != nwr || pix_data != 4'd3) bad++;
        if (first_idx < 0) first_idx = i;
        last_idx = i;
        nwr++;
      end
      if (show) begin
        show_cnt++;
        show_idx = i;
      end
      if (i == 5)  begin op_code = 8'h19; op_valid = 1'b1; end
      if (i == 6)  op_valid = 1'b0;
      if (i == 10) begin op_code = 8'h10; op_valid = 1'b1; end
      if (i == 11) op_valid = 1'b0;
      tick();
    end
    check_eq("clr_busy_cycles", 32'(busy_cnt), 32'd240);
    check_eq("clr_nwrites",     32'(nwr), 32'd240);
    check_eq("clr_seq_errors",  32'(bad), 32'd0);
    check_eq("clr_first_idx",   32'(first_idx), 32'd1);
    check_eq("clr_last_idx",    32'(last_idx), 32'd240);
    check_eq("show_count",      32'(show_cnt), 32'd1);
    check_eq("show_idx",        32'(show_idx), 32'd241);

    // Zero-width fill does nothing
    send_cmd(8'h17, 5, {8'h00, 8'h00, 8'h00, 8'h05, 8'h07});
    busy_cnt = 0; nwr = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy) busy_cnt++;
      if (pix_we) nwr++;
      tick();
    end
    check_eq("zero_fill_busy",   32'(busy_cnt), 32'd0);
    check_eq("zero_fill_writes", 32'(nwr), 32'd0);

    // Reset in the middle of a clear
    send_cmd(8'h10, 0, 40'h0);
    idle(52);
    check_eq("pre_rst_we", 32'(pix_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_we",   32'(pix_we), 32'd0);
    check_eq("async_rst_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_cursor", 32'({cur_x, cur_y}), 32'd0);
    check_eq("post_rst_width",  32'(spr_width), 32'd25);
    busy_cnt = 0; nwr = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) busy_cnt++;
      if (pix_we) nwr++;
      tick();
    end
    check_eq("post_rst_busy",   32'(busy_cnt), 32'd0);
    check_eq("post_rst_writes", 32'(nwr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
